// File: rtl/mcb_port_sequencer.sv
// Shares one 32-bit MCB user port between two burst requesters.
// Requester 0 is the pixel writer and requester 1 is the line fetcher.
// Only one burst runs at a time. A write fills the MCB write FIFO before its
// command is issued. A read issues its command first, then drains the read FIFO.
module mcb_port_sequencer #(
    parameter bit          PRIO_FIXED = 1'b0,
    parameter int unsigned RD_TIMEOUT = 1024,
    parameter int unsigned TO_W       = 11
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        calib_done,
    input  logic [1:0]  req,
    input  logic [1:0]  req_we,
    input  logic [59:0] req_addr,
    input  logic [11:0] req_bl,
    output logic [1:0]  gnt,
    input  logic [63:0] wdata,
    output logic [1:0]  wdata_pop,
    output logic [31:0] rdata,
    output logic [1:0]  rdata_vld,
    output logic [1:0]  done,
    output logic        rd_err,
    output logic        cmd_en,
    output logic [2:0]  cmd_instr,
    output logic [5:0]  cmd_bl,
    output logic [29:0] cmd_byte_addr,
    input  logic        cmd_full,
    output logic        wr_en,
    output logic [31:0] wr_data,
    output logic [3:0]  wr_mask,
    input  logic        wr_full,
    output logic        rd_en,
    input  logic [31:0] rd_data,
    input  logic        rd_empty
);

    localparam int unsigned AW  = 30;
    localparam int unsigned BLW = 6;
    localparam int unsigned DW  = 32;

    localparam logic [2:0] INSTR_WR = 3'b000;
    localparam logic [2:0] INSTR_RD = 3'b001;

    typedef enum logic [2:0] {
        S_WAIT_CAL,
        S_IDLE,
        S_WR_FILL,
        S_WR_CMD,
        S_RD_CMD,
        S_RD_DRAIN,
        S_DONE
    } state_e;

    state_e          state_q, state_d;
    logic            id_q, id_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [BLW-1:0]  bl_q, bl_d;
    logic [BLW-1:0]  cnt_q, cnt_d;
    logic [TO_W-1:0] wd_q, wd_d;
    logic            rr_q, rr_d;
    logic [1:0]      gnt_q, gnt_d;
    logic            rd_err_q, rd_err_d;

    logic            sel_c;
    logic            sel_we_c;
    logic [AW-1:0]   sel_addr_c;
    logic [BLW-1:0]  sel_bl_c;
    logic [DW-1:0]   sel_wdata_c;

    // Arbitration: a single request wins outright; a tie goes to the rr pointer or to requester 0
    always_comb begin
        if (req == 2'b11) begin
            sel_c = PRIO_FIXED ? 1'b0 : rr_q;
        end else begin
            sel_c = ~req[0];
        end
        sel_we_c    = sel_c ? req_we[1]       : req_we[0];
        sel_addr_c  = sel_c ? req_addr[59:30] : req_addr[29:0];
        sel_bl_c    = sel_c ? req_bl[11:6]    : req_bl[5:0];
        sel_wdata_c = id_q  ? wdata[63:32]    : wdata[31:0];
    end

    // State and burst context registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_WAIT_CAL;
            id_q     <= 1'b0;
            addr_q   <= '0;
            bl_q     <= '0;
            cnt_q    <= '0;
            wd_q     <= '0;
            rr_q     <= 1'b0;
            gnt_q    <= '0;
            rd_err_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            id_q     <= id_d;
            addr_q   <= addr_d;
            bl_q     <= bl_d;
            cnt_q    <= cnt_d;
            wd_q     <= wd_d;
            rr_q     <= rr_d;
            gnt_q    <= gnt_d;
            rd_err_q <= rd_err_d;
        end
    end

    // Next state and MCB/requester handshakes; bus fields are zero outside their active states
    always_comb begin
        state_d       = state_q;
        id_d          = id_q;
        addr_d        = addr_q;
        bl_d          = bl_q;
        cnt_d         = cnt_q;
        wd_d          = wd_q;
        rr_d          = rr_q;
        gnt_d         = '0;
        rd_err_d      = rd_err_q;

        done          = '0;
        wdata_pop     = '0;
        rdata         = '0;
        rdata_vld     = '0;
        cmd_en        = 1'b0;
        cmd_instr     = '0;
        cmd_bl        = '0;
        cmd_byte_addr = '0;
        wr_en         = 1'b0;
        wr_data       = '0;
        rd_en         = 1'b0;

        unique case (state_q)
            S_WAIT_CAL: begin
                if (calib_done) begin
                    state_d = S_IDLE;
                end
            end

            S_IDLE: begin
                if (req != 2'b00) begin
                    id_d         = sel_c;
                    addr_d       = sel_addr_c & ~AW'(3);
                    bl_d         = sel_bl_c;
                    cnt_d        = '0;
                    gnt_d[sel_c] = 1'b1;
                    rr_d         = ~sel_c;
                    state_d      = sel_we_c ? S_WR_FILL : S_RD_CMD;
                end
            end

            S_WR_FILL: begin
                wr_en           = ~wr_full;
                wr_data         = sel_wdata_c;
                wdata_pop[id_q] = ~wr_full;
                if (!wr_full) begin
                    if (cnt_q == bl_q) begin
                        state_d = S_WR_CMD;
                    end else begin
                        cnt_d = cnt_q + BLW'(1);
                    end
                end
            end

            S_WR_CMD: begin
                cmd_en        = ~cmd_full;
                cmd_instr     = INSTR_WR;
                cmd_bl        = bl_q;
                cmd_byte_addr = addr_q;
                if (!cmd_full) begin
                    state_d = S_DONE;
                end
            end

            S_RD_CMD: begin
                cmd_en        = ~cmd_full;
                cmd_instr     = INSTR_RD;
                cmd_bl        = bl_q;
                cmd_byte_addr = addr_q;
                if (!cmd_full) begin
                    wd_d    = '0;
                    state_d = S_RD_DRAIN;
                end
            end

            S_RD_DRAIN: begin
                rd_en           = ~rd_empty;
                rdata           = rd_data;
                rdata_vld[id_q] = ~rd_empty;
                if (!rd_empty) begin
                    wd_d = '0;
                    if (cnt_q == bl_q) begin
                        state_d = S_DONE;
                    end else begin
                        cnt_d = cnt_q + BLW'(1);
                    end
                end else begin
                    wd_d = wd_q + TO_W'(1);
                    if ((RD_TIMEOUT != 0) && ((wd_q + TO_W'(1)) == TO_W'(RD_TIMEOUT))) begin
                        rd_err_d = 1'b1;
                        state_d  = S_DONE;
                    end
                end
            end

            S_DONE: begin
                done[id_q] = 1'b1;
                state_d    = S_IDLE;
            end

            default: begin
                state_d = S_WAIT_CAL;
            end
        endcase
    end

    assign gnt     = gnt_q;
    assign rd_err  = rd_err_q;
    assign wr_mask = 4'b0000;

endmodule

// File: tb/tb_mcb_port_sequencer.sv
// Scoreboard bench for mcb_port_sequencer: a requester/MCB environment, queued expected events, a negedge monitor.
module tb_mcb_port_sequencer;

    localparam int K_GNT  = 0;
    localparam int K_WR   = 1;
    localparam int K_CMD  = 2;
    localparam int K_RD   = 3;
    localparam int K_DONE = 4;

    typedef struct {
        int          kind;
        logic [31:0] a;
        logic [31:0] b;
    } ev_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        calib_done;
    logic [1:0]  req, req_we;
    logic [59:0] req_addr;
    logic [11:0] req_bl;
    logic [63:0] wdata;
    logic        cmd_full, wr_full, rd_empty;
    logic [31:0] rd_data;

    logic [1:0]  gnt, wdata_pop, rdata_vld, done;
    logic [31:0] rdata, wr_data;
    logic        rd_err, cmd_en, wr_en, rd_en;
    logic [2:0]  cmd_instr;
    logic [5:0]  cmd_bl;
    logic [29:0] cmd_byte_addr;
    logic [3:0]  wr_mask;

    // Second instance with fixed priority; its MCB side never stalls
    logic [1:0]  req_f;
    logic [1:0]  gnt_f, wdata_pop_f, rdata_vld_f, done_f;
    logic [31:0] rdata_f, wr_data_f;
    logic        rd_err_f, cmd_en_f, wr_en_f, rd_en_f;
    logic [2:0]  cmd_instr_f;
    logic [5:0]  cmd_bl_f;
    logic [29:0] cmd_byte_addr_f;
    logic [3:0]  wr_mask_f;

    int checks = 0;
    int errors = 0;

    ev_t         expq[$];
    logic [31:0] wq0[$], wq1[$], rdq[$];
    bit          rd_toggle = 1'b0;

    mcb_port_sequencer #(.PRIO_FIXED(1'b0), .RD_TIMEOUT(16), .TO_W(11)) u_dut (
        .clk(clk), .reset(reset), .calib_done(calib_done),
        .req(req), .req_we(req_we), .req_addr(req_addr), .req_bl(req_bl),
        .gnt(gnt), .wdata(wdata), .wdata_pop(wdata_pop),
        .rdata(rdata), .rdata_vld(rdata_vld), .done(done), .rd_err(rd_err),
        .cmd_en(cmd_en), .cmd_instr(cmd_instr), .cmd_bl(cmd_bl),
        .cmd_byte_addr(cmd_byte_addr), .cmd_full(cmd_full),
        .wr_en(wr_en), .wr_data(wr_data), .wr_mask(wr_mask), .wr_full(wr_full),
        .rd_en(rd_en), .rd_data(rd_data), .rd_empty(rd_empty)
    );

    mcb_port_sequencer #(.PRIO_FIXED(1'b1), .RD_TIMEOUT(16), .TO_W(11)) u_fix (
        .clk(clk), .reset(reset), .calib_done(calib_done),
        .req(req_f), .req_we(2'b00), .req_addr(req_addr), .req_bl(12'd0),
        .gnt(gnt_f), .wdata(wdata), .wdata_pop(wdata_pop_f),
        .rdata(rdata_f), .rdata_vld(rdata_vld_f), .done(done_f), .rd_err(rd_err_f),
        .cmd_en(cmd_en_f), .cmd_instr(cmd_instr_f), .cmd_bl(cmd_bl_f),
        .cmd_byte_addr(cmd_byte_addr_f), .cmd_full(1'b0),
        .wr_en(wr_en_f), .wr_data(wr_data_f), .wr_mask(wr_mask_f), .wr_full(1'b0),
        .rd_en(rd_en_f), .rd_data(32'h0), .rd_empty(1'b0)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "global timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic string kname(int k);
        case (k)
            K_GNT:   return "gnt";
            K_WR:    return "wr";
            K_CMD:   return "cmd";
            K_RD:    return "rd";
            default: return "done";
        endcase
    endfunction

    function automatic void exp_ev(int k, logic [31:0] a, logic [31:0] b);
        ev_t e;
        e.kind = k;
        e.a    = a;
        e.b    = b;
        expq.push_back(e);
    endfunction

    // Expected events of one write burst: grant, bl+1 data words, write command, done
    function automatic void exp_write(int id, logic [29:0] addr, int bl, logic [31:0] base);
        exp_ev(K_GNT, 32'(1 << id), 32'h0);
        for (int i = 0; i <= bl; i++) exp_ev(K_WR, base + 32'(i), 32'((1 << id) << 4));
        exp_ev(K_CMD, {2'b00, addr & ~30'h3}, 32'(bl));
        exp_ev(K_DONE, 32'(1 << id), 32'h0);
    endfunction

    // Expected events of one read burst delivering n words
    function automatic void exp_read(int id, logic [29:0] addr, int bl, int n, logic [31:0] base);
        exp_ev(K_GNT, 32'(1 << id), 32'h0);
        exp_ev(K_CMD, {2'b00, addr & ~30'h3}, 32'h40 | 32'(bl));
        for (int i = 0; i < n; i++) exp_ev(K_RD, base + 32'(i), 32'(1 << id));
        exp_ev(K_DONE, 32'(1 << id), 32'h0);
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic observe(input int k, input logic [31:0] a, input logic [31:0] b);
        ev_t e;
        checks++;
        if (expq.size() == 0) begin
            errors++;
            $display("FAIL sb_unexpected_%s: got a=%h b=%h expected no event", kname(k), a, b);
        end else begin
            e = expq.pop_front();
            if (e.kind != k || e.a !== a || e.b !== b) begin
                errors++;
                $display("FAIL sb_%s: got %s a=%h b=%h expected %s a=%h b=%h",
                         kname(k), kname(k), a, b, kname(e.kind), e.a, e.b);
            end
        end
    endtask

    task automatic wait_done(input int id, input int budget, output int lat);
        lat = -1;
        for (int i = 1; i <= budget; i++) begin
            tick();
            if (done[id]) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic wait_gnt(input int id, input int budget, output int lat);
        lat = -1;
        for (int i = 1; i <= budget; i++) begin
            tick();
            if (gnt[id]) begin
                lat = i;
                break;
            end
        end
    endtask

    // Requester show-ahead data and MCB read FIFO model; pops apply after the edge that consumed them
    initial begin
        bit p0, p1, pr, tog;
        logic [31:0] tmp;
        wdata    = '0;
        rd_empty = 1'b1;
        rd_data  = '0;
        tog      = 1'b0;
        forever begin
            @(negedge clk);
            p0 = wdata_pop[0];
            p1 = wdata_pop[1];
            pr = rd_en;
            @(posedge clk);
            #1;
            if (p0 && wq0.size() > 0) tmp = wq0.pop_front();
            if (p1 && wq1.size() > 0) tmp = wq1.pop_front();
            if (pr && rdq.size() > 0) tmp = rdq.pop_front();
            wdata[31:0]  = (wq0.size() > 0) ? wq0[0] : 32'h0;
            wdata[63:32] = (wq1.size() > 0) ? wq1[0] : 32'h0;
            tog = ~tog;
            if (rdq.size() > 0 && !(rd_toggle && tog)) begin
                rd_empty = 1'b0;
                rd_data  = rdq[0];
            end else begin
                rd_empty = 1'b1;
                rd_data  = 32'h0;
            end
        end
    end

    // Monitor: every DUT event is popped from the scoreboard in a fixed intra-cycle order
    initial forever begin
        @(negedge clk);
        if (!reset) begin
            if (gnt != 2'b00)       observe(K_GNT, {30'h0, gnt}, 32'h0);
            if (wr_en)              observe(K_WR, wr_data, {26'h0, wdata_pop, wr_mask});
            if (cmd_en)             observe(K_CMD, {2'b00, cmd_byte_addr}, {23'h0, cmd_instr, cmd_bl});
            if (rdata_vld != 2'b00) observe(K_RD, rdata, {30'h0, rdata_vld});
            if (done != 2'b00)      observe(K_DONE, {30'h0, done}, 32'h0);
            if (cmd_en || wr_en || rd_en) begin
                checks++;
                if ((int'(cmd_en) + int'(wr_en) + int'(rd_en) > 1) ||
                    (cmd_en && cmd_full) || (wr_en && wr_full) || (rd_en && rd_empty)) begin
                    errors++;
                    $display("FAIL mcb_handshake: got cmd_en=%b wr_en=%b rd_en=%b full=%b%b empty=%b expected one enable and no push into full/pop from empty",
                             cmd_en, wr_en, rd_en, cmd_full, wr_full, rd_empty);
                end
            end
        end
    end

    initial begin
        int bad, lat, n, nf;
        reset = 1'b1; calib_done = 1'b0; req = '0; req_we = '0; req_addr = '0; req_bl = '0;
        cmd_full = 1'b0; wr_full = 1'b0; req_f = '0;
        repeat (3) tick();
        chk("reset_ctrl", {gnt, done, wdata_pop, rdata_vld, cmd_en, wr_en, rd_en, rd_err}, 64'h0);
        chk("reset_bus", {cmd_instr, cmd_bl, cmd_byte_addr, wr_data, wr_mask}, 64'h0);
        chk("reset_rdata", rdata, 64'h0);
        reset = 1'b0;

        // Held off before calibration, then a 4-word write from requester 0
        wq0.push_back(32'h1); wq0.push_back(32'h2); wq0.push_back(32'h3); wq0.push_back(32'h4);
        exp_write(0, 30'h100, 3, 32'h1);
        req_we[0] = 1'b1; req_addr[29:0] = 30'h100; req_bl[5:0] = 6'd3; req[0] = 1'b1;
        bad = 0;
        repeat (50) begin
            tick();
            if (gnt != 2'b00 || cmd_en) bad++;
        end
        chk("calib_hold", 64'(bad), 64'd0);
        calib_done = 1'b1;
        tick(); chk("gnt_after_cal_1", {62'h0, gnt}, 64'h0);
        tick(); chk("gnt_after_cal_2", {62'h0, gnt}, 64'h1);
        req[0] = 1'b0;
        wait_done(0, 40, lat);
        chk("wr4_latency", 64'(lat), 64'd5);

        // Same write size with wr_full high in burst cycles 2-5; address low bits are dropped
        wq0.push_back(32'hA0); wq0.push_back(32'hA1); wq0.push_back(32'hA2); wq0.push_back(32'hA3);
        exp_write(0, 30'h2A7, 3, 32'hA0);
        tick();
        req_addr[29:0] = 30'h2A7; req[0] = 1'b1;
        wait_gnt(0, 20, lat);
        chk("wr_stall_gnt", 64'(lat), 64'd1);
        req[0] = 1'b0;
        tick(); wr_full = 1'b1;
        repeat (4) tick();
        wr_full = 1'b0;
        wait_done(0, 40, lat);
        chk("wr_stall_latency", 64'(lat), 64'd4);

        // Single-word write from requester 1 (shortest burst)
        wq1.push_back(32'hC0);
        exp_write(1, 30'h400, 0, 32'hC0);
        tick();
        req_we[1] = 1'b1; req_addr[59:30] = 30'h400; req_bl[11:6] = 6'd0; req[1] = 1'b1;
        wait_gnt(1, 20, lat);
        chk("wr1_gnt", 64'(lat), 64'd1);
        req[1] = 1'b0;
        wait_done(1, 20, lat);
        chk("wr1_latency", 64'(lat), 64'd2);

        // Both requesters held with 1-word reads: grants alternate 0,1,0,1
        rdq.push_back(32'h11); rdq.push_back(32'h22); rdq.push_back(32'h33); rdq.push_back(32'h44);
        exp_read(0, 30'h1000, 0, 1, 32'h11);
        exp_read(1, 30'h2000, 0, 1, 32'h22);
        exp_read(0, 30'h1000, 0, 1, 32'h33);
        exp_read(1, 30'h2000, 0, 1, 32'h44);
        tick();
        req_we = 2'b00; req_addr = {30'h2000, 30'h1000}; req_bl = '0; req = 2'b11;
        n = 0;
        for (int i = 0; i < 80; i++) begin
            tick();
            if (done != 2'b00) n++;
            if (n == 4) break;
        end
        req = 2'b00;
        chk("alt_done_count", 64'(n), 64'd4);

        // 8-word read for requester 1 with a sparse read FIFO and a full command FIFO
        for (int i = 0; i < 8; i++) rdq.push_back(32'hB0 + 32'(i));
        exp_read(1, 30'h3000, 7, 8, 32'hB0);
        rd_toggle = 1'b1; cmd_full = 1'b1;
        tick();
        req_addr[59:30] = 30'h3000; req_bl[11:6] = 6'd7; req[1] = 1'b1;
        wait_gnt(1, 20, lat);
        chk("rd8_gnt", 64'(lat), 64'd1);
        req[1] = 1'b0;
        repeat (3) tick();
        chk("rd8_cmd_held", {63'h0, cmd_en}, 64'h0);
        cmd_full = 1'b0;
        wait_done(1, 100, lat);
        chk("rd8_done_seen", {63'h0, lat > 0}, 64'h1);
        rd_toggle = 1'b0;

        // Read of 4 words with only 2 returned: watchdog aborts after 16 empty cycles
        rdq.push_back(32'hD0); rdq.push_back(32'hD1);
        exp_read(0, 30'h500, 3, 2, 32'hD0);
        tick();
        req_addr[29:0] = 30'h500; req_bl[5:0] = 6'd3; req_we[0] = 1'b0; req[0] = 1'b1;
        wait_gnt(0, 20, lat);
        chk("to_gnt", 64'(lat), 64'd1);
        req[0] = 1'b0;
        chk("to_rd_err_start", {63'h0, rd_err}, 64'h0);
        repeat (18) tick();
        chk("to_rd_err_early", {63'h0, rd_err}, 64'h0);
        chk("to_done_early", {62'h0, done}, 64'h0);
        tick();
        chk("to_done", {62'h0, done}, 64'h1);
        chk("to_rd_err_set", {63'h0, rd_err}, 64'h1);

        // Back in IDLE after the abort: a 2-word write from requester 1; rd_err stays set
        wq1.push_back(32'hE0); wq1.push_back(32'hE1);
        exp_write(1, 30'h600, 1, 32'hE0);
        tick();
        req_we[1] = 1'b1; req_addr[59:30] = 30'h600; req_bl[11:6] = 6'd1; req[1] = 1'b1;
        wait_gnt(1, 20, lat);
        chk("post_to_gnt", 64'(lat), 64'd1);
        req[1] = 1'b0;
        wait_done(1, 20, lat);
        chk("post_to_latency", 64'(lat), 64'd3);
        chk("rd_err_sticky", {63'h0, rd_err}, 64'h1);

        // Reset clears the sticky error
        tick();
        reset = 1'b1;
        tick();
        chk("reset_rd_err", {63'h0, rd_err}, 64'h0);
        chk("reset_ctrl_2", {gnt, done, cmd_en, wr_en, rd_en}, 64'h0);
        reset = 1'b0;
        tick();

        // Fixed priority: with both requests held only requester 0 is ever granted
        req_f = 2'b11;
        nf = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (gnt_f != 2'b00) begin
                nf++;
                chk("fix_gnt", {62'h0, gnt_f}, 64'h1);
            end
        end
        req_f = 2'b00;
        chk("fix_gnt_count", {63'h0, nf >= 8}, 64'h1);

        repeat (5) tick();
        chk("sb_drained", 64'(expq.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
